bidir_mux_port: RTL

Parametrised bidirectional port with an N-channel transmit multiplexer. It drives a registered channel selection onto a shared tristate bus when transmitting and samples the bus when receiving. Direction changes pass through a fixed number of dead (high-Z) turnaround cycles, so the bus is never driven from both ends. It sits between the core datapath and a shared inout pad group, replacing ad-hoc `oe ? reg : 'z` assigns.

---
 rtl/bidir_mux_port.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/bidir_mux_port.sv
// Bidirectional pad port: N-channel transmit mux onto a shared tristate bus,
// with dead turnaround cycles on direction change. Optional readback check: BIDIR_READBACK_EN.
module bidir_mux_port #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int TURN  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH*WIDTH-1:0]     d,
    input  logic [$clog2(NCH)-1:0]   sel,
    input  logic                     dir_req,
    inout  wire  [WIDTH-1:0]         io,
    output logic                     oe,
    output logic [WIDTH-1:0]         rx_data,
    output logic                     rx_valid,
    output logic                     busy,
    output logic                     err,
    input  logic                     err_clr
);

    localparam logic [3:0] TURN_LD = (TURN > 0) ? 4'(TURN - 1) : 4'd0;

    typedef enum logic [1:0] {
        RX      = 2'd0,
        TURN_TX = 2'd1,
        TX      = 2'd2,
        TURN_RX = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   tx_reg_q, tx_reg_d;
    logic [WIDTH-1:0]   rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;

    // Out-of-range selects (non power-of-two NCH) fall through to zero.
    always_comb begin
        tx_reg_d = '0;
        for (int k = 0; k < NCH; k++) begin
            if (int'(sel) == k) begin
                tx_reg_d = d[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RX: begin
                if (dir_req) begin
                    if (TURN == 0) begin
                        state_d = TX;
                    end else begin
                        state_d = TURN_TX;
                        cnt_d   = TURN_LD;
                    end
                end
            end
            TURN_TX: begin
                if (cnt_q == 4'd0) state_d = TX;
                else               cnt_d   = cnt_q - 4'd1;
            end
            TX: begin
                if (!dir_req) begin
                    if (TURN == 0) begin
                        state_d = RX;
                    end else begin
                        state_d = TURN_RX;
                        cnt_d   = TURN_LD;
                    end
                end
            end
            TURN_RX: begin
                if (cnt_q == 4'd0) state_d = RX;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: begin
                state_d = RX;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        rx_valid_d = (state_q == RX);
        rx_data_d  = (state_q == RX) ? io : rx_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RX;
            cnt_q      <= 4'd0;
            tx_reg_q   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_reg_q   <= tx_reg_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // Outputs decode straight from the state flop so reset releases the bus at once.
    assign oe       = (state_q == TX);
    assign busy     = (state_q == TURN_TX) || (state_q == TURN_RX);
    assign io       = oe ? tx_reg_q : 'z;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

`ifdef BIDIR_READBACK_EN
    logic first_tx_q, first_tx_d;
    logic err_q, err_d;

    // The first TX cycle is skipped while the pad settles after turnaround.
    always_comb begin
        first_tx_d = (state_d == TX) && (state_q != TX);
        err_d      = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end else if ((state_q == TX) && !first_tx_q && (io !== tx_reg_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_tx_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            first_tx_q <= first_tx_d;
            err_q      <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err            = 1'b0;
`endif

endmodule
